idct_stage1_inv4: RTL and testbench

Pipelined inverse of the forward DCT butterfly/rotation stage. It sits at the input of the 8-point IDCT datapath and undoes the odd-part butterfly and √2 scaling, so that the downstream IDCT stages can run the remaining inverse butterflies. One 8-coefficient row is accepted per handshake through a 2-stage valid/ready pipeline with back-pressure. It tracks row position within an 8-row block and reports arithmetic saturation.

---
 rtl/idct_stage1_inv4.sv | 201 ++++++++++++++++++++
 tb/tb_idct_stage1_inv4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/idct_stage1_inv4.sv
// Input stage of the 8-point IDCT: undoes the odd-part butterfly and sqrt(2)
// scaling of the forward stage, one row per handshake through a 2-deep pipeline.
module idct_stage1_inv4 (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [10:0] y0,
    input  logic signed [10:0] y1,
    input  logic signed [25:0] y2,
    input  logic signed [25:0] y3,
    input  logic signed [26:0] y4,
    input  logic signed [26:0] y5,
    input  logic signed [26:0] y6,
    input  logic signed [26:0] y7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [10:0] x0,
    output logic signed [10:0] x1,
    output logic signed [25:0] x2,
    output logic signed [25:0] x3,
    output logic signed [25:0] x4,
    output logic signed [25:0] x5,
    output logic signed [25:0] x6,
    output logic signed [25:0] x7,
    output logic               out_last,
    output logic               sat,
    input  logic               sat_clr
);

    localparam int W = 28;
    localparam int NT = 6;
    localparam int SHIFT [NT] = '{1, 3, 4, 6, 8, 14};
    localparam logic signed [W-1:0] SAT_MAX = 28'sh1FFFFFF;
    localparam logic signed [W-1:0] SAT_MIN = 28'shE000000;

    function automatic logic signed [25:0] clamp26(input logic signed [W-1:0] v);
        if (v > SAT_MAX)      return 26'sh1FFFFFF;
        else if (v < SAT_MIN) return 26'sh2000000;
        else                  return v[25:0];
    endfunction

    function automatic logic out_of_range(input logic signed [W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // Handshake / advance controls
    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv, out_hs;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2_valid_q && out_ready;

    // Stage 1: sums/differences and the individually floored shift terms
    logic signed [W-1:0] y4_w, y5_w, y6_w, y7_w;
    logic signed [W-1:0] s1_sum_d, s1_diff_d;
    logic signed [W-1:0] s1_t5_d [NT];
    logic signed [W-1:0] s1_t6_d [NT];

    logic signed [10:0]  s1_x0_q, s1_x1_q;
    logic signed [25:0]  s1_x2_q, s1_x3_q;
    logic signed [W-1:0] s1_sum_q, s1_diff_q;
    logic signed [W-1:0] s1_t5_q [NT];
    logic signed [W-1:0] s1_t6_q [NT];

    assign y4_w = W'(y4);
    assign y5_w = W'(y5);
    assign y6_w = W'(y6);
    assign y7_w = W'(y7);

    always_comb begin
        s1_sum_d  = y7_w + y4_w;
        s1_diff_d = y7_w - y4_w;
        for (int i = 0; i < NT; i++) begin
            s1_t5_d[i] = y5_w >>> SHIFT[i];
            s1_t6_d[i] = y6_w >>> SHIFT[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x0_q    <= '0;
            s1_x1_q    <= '0;
            s1_x2_q    <= '0;
            s1_x3_q    <= '0;
            s1_sum_q   <= '0;
            s1_diff_q  <= '0;
            for (int i = 0; i < NT; i++) begin
                s1_t5_q[i] <= '0;
                s1_t6_q[i] <= '0;
            end
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_x0_q   <= y0;
                s1_x1_q   <= y1;
                s1_x2_q   <= y2;
                s1_x3_q   <= y3;
                s1_sum_q  <= s1_sum_d;
                s1_diff_q <= s1_diff_d;
                for (int i = 0; i < NT; i++) begin
                    s1_t5_q[i] <= s1_t5_d[i];
                    s1_t6_q[i] <= s1_t6_d[i];
                end
            end
        end
    end

    // Stage 2: halve, sum the 1/sqrt(2) terms, then clamp to 26 bits
    logic signed [W-1:0] x4_raw, x5_raw, x6_raw, x7_raw;
    logic signed [25:0]  x4_d, x5_d, x6_d, x7_d;
    logic                ovf_d;

    // NOTE: every combinational output gets a default before any branch or
    // loop so no latch can be inferred.
    always_comb begin
        x4_raw = s1_diff_q >>> 1;
        x7_raw = s1_sum_q >>> 1;
        x5_raw = '0;
        x6_raw = '0;
        for (int i = 0; i < NT; i++) begin
            x5_raw = x5_raw + s1_t5_q[i];
            x6_raw = x6_raw + s1_t6_q[i];
        end
        x4_d  = clamp26(x4_raw);
        x5_d  = clamp26(x5_raw);
        x6_d  = clamp26(x6_raw);
        x7_d  = clamp26(x7_raw);
        ovf_d = out_of_range(x4_raw) || out_of_range(x5_raw) ||
                out_of_range(x6_raw) || out_of_range(x7_raw);
    end

    logic signed [10:0] s2_x0_q, s2_x1_q;
    logic signed [25:0] s2_x2_q, s2_x3_q, s2_x4_q, s2_x5_q, s2_x6_q, s2_x7_q;
    logic               s2_ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_x0_q    <= '0;
            s2_x1_q    <= '0;
            s2_x2_q    <= '0;
            s2_x3_q    <= '0;
            s2_x4_q    <= '0;
            s2_x5_q    <= '0;
            s2_x6_q    <= '0;
            s2_x7_q    <= '0;
            s2_ovf_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_x0_q  <= s1_x0_q;
                s2_x1_q  <= s1_x1_q;
                s2_x2_q  <= s1_x2_q;
                s2_x3_q  <= s1_x3_q;
                s2_x4_q  <= x4_d;
                s2_x5_q  <= x5_d;
                s2_x6_q  <= x6_d;
                s2_x7_q  <= x7_d;
                s2_ovf_q <= ovf_d;
            end
        end
    end

    // Row position within the 8-row block and sticky saturation flag
    logic [2:0] row_q, row_d;
    logic       sat_q, sat_d;

    always_comb begin
        row_d = out_hs ? row_q + 3'd1 : row_q;
        sat_d = (sat_q && !sat_clr) || (out_hs && s2_ovf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= 3'd0;
            sat_q <= 1'b0;
        end else begin
            row_q <= row_d;
            sat_q <= sat_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_last  = s2_valid_q && (row_q == 3'd7);
    assign sat       = sat_q;
    assign x0 = s2_x0_q;
    assign x1 = s2_x1_q;
    assign x2 = s2_x2_q;
    assign x3 = s2_x3_q;
    assign x4 = s2_x4_q;
    assign x5 = s2_x5_q;
    assign x6 = s2_x6_q;
    assign x7 = s2_x7_q;

endmodule

// File: tb/tb_idct_stage1_inv4.sv
// Directed bench for idct_stage1_inv4: hand-computed rows, saturation, stalls,
// block framing, mid-stream reset and forward/inverse round trip.
module tb_idct_stage1_inv4;

    logic               clk = 1'b0;
    logic               reset, in_valid, in_ready, out_valid, out_ready;
    logic               out_last, sat, sat_clr;
    logic signed [10:0] y0, y1, x0, x1;
    logic signed [25:0] y2, y3, x2, x3, x4, x5, x6, x7;
    logic signed [26:0] y4, y5, y6, y7;

    int errors = 0;
    int checks = 0;
    int exp_row = 0;

    always #5 clk = ~clk;

    idct_stage1_inv4 dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .out_last(out_last), .sat(sat), .sat_clr(sat_clr)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input int v0, v1, v2, v3, v4, v5, v6, v7);
        y0 = 11'(v0); y1 = 11'(v1); y2 = 26'(v2); y3 = 26'(v3);
        y4 = 27'(v4); y5 = 27'(v5); y6 = 27'(v6); y7 = 27'(v7);
    endtask

    // Stream row k: x0 = k, x2 = 3k, x4 = k, x7 = 2k
    task automatic set_row(input int k);
        set_vals(k, -k, 3 * k, 0, k, 0, 0, 3 * k);
    endtask

    task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                              input int base);
        int sent = 0;
        int recv = 0;
        logic hs_in;
        logic prev_stall = 1'b0;
        logic signed [10:0] prev_x0 = '0;
        for (int c = 0; c < n + 40 && recv < n; c++) begin
            out_ready = !(c >= stall_lo && c <= stall_hi);
            in_valid  = (sent < n);
            set_row(base + sent);
            #1;
            check("in_ready", in_ready, !((sent - recv) == 2 && !out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_x0", x0, prev_x0);
            end
            if (out_valid && out_ready) begin
                check("str_x0", x0, base + recv);
                check("str_x2", x2, 3 * (base + recv));
                check("str_x4", x4, base + recv);
                check("str_x7", x7, 2 * (base + recv));
                check("str_last", out_last, exp_row == 7);
                exp_row = (exp_row + 1) % 8;
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_x0    = x0;
            hs_in      = in_valid && in_ready;
            @(posedge clk);
            if (hs_in) sent++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("str_count", recv, n);
        #1;
        check("str_drained", out_valid, 0);
    endtask

    initial begin
        int d5, d6;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        set_vals(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_x0", x0, 0);
        check("rst_x4", x4, 0);
        check("rst_last", out_last, 0);
        check("rst_sat", sat, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic row, presented two edges after being offered
        set_vals(5, -3, 100, -200, 10, 1414, -1414, 30);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bas_lat1", out_valid, 0);
        tick();
        check("bas_valid", out_valid, 1);
        check("bas_x0", x0, 5);
        check("bas_x1", x1, -3);
        check("bas_x2", x2, 100);
        check("bas_x3", x3, -200);
        check("bas_x4", x4, 10);
        check("bas_x5", x5, 998);
        check("bas_x6", x6, -1003);
        check("bas_x7", x7, 20);
        check("bas_sat", sat, 0);
        tick();
        check("bas_gone", out_valid, 0);
        exp_row = 1;

        // Saturation: x4 clamps to the positive limit, sat is sticky
        set_vals(0, 0, 0, 0, -67108864, 0, 0, 67108863);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("sat_x4", x4, 33554431);
        check("sat_x7", x7, -1);
        check("sat_before_hs", sat, 0);
        tick();
        check("sat_set", sat, 1);
        set_vals(5, -3, 100, -200, 10, 1414, -1414, 30);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("sat_clean_x4", x4, 10);
        tick();
        check("sat_sticky", sat, 1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_cleared", sat, 0);
        exp_row = 3;

        // Round trip from forward-stage outputs
        set_vals(0, 0, 0, 0, -8388607 - 8388607, 1414, -56569, 0);
        in_valid = 1'b1;
        tick();
        set_vals(0, 0, 0, 0, 3000000 + 5000000, 56569, -1414, 3000000 - 5000000);
        tick();
        in_valid = 1'b0;
        check("rt_a_x4", x4, 8388607);
        check("rt_a_x7", x7, -8388607);
        check("rt_a_x5", x5, 998);
        check("rt_a_x6", x6, -40002);
        d5 = int'(x5) - 1000;
        d6 = int'(x6) + 40000;
        check("rt_a_tol", (d5 <= 8 && d5 >= -8 && d6 <= 8 && d6 >= -8), 1);
        tick();
        check("rt_b_x4", x4, -5000000);
        check("rt_b_x7", x7, 3000000);
        check("rt_b_x5", x5, 39996);
        check("rt_b_x6", x6, -1003);
        d5 = int'(x5) - 40000;
        d6 = int'(x6) + 1000;
        check("rt_b_tol", (d5 <= 8 && d5 >= -8 && d6 <= 8 && d6 >= -8), 1);
        tick();
        check("rt_sat", sat, 0);
        exp_row = 5;

        // Back-pressure: out_ready low for stream cycles 3..7
        run_stream(5, 3, 7, 10);

        // Block framing from a clean counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_row = 0;
        run_stream(16, 100, -1, 20);

        // Reset with two rows in flight after the counter has moved
        run_stream(3, 100, -1, 40);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_row(60);
        tick();
        set_row(61);
        tick();
        in_valid = 1'b0;
        check("mid_full_valid", out_valid, 1);
        check("mid_full_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_x0", x0, 0);
        check("mid_rst_x4", x4, 0);
        check("mid_rst_x7", x7, 0);
        check("mid_rst_last", out_last, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_row = 0;
        tick();
        check("mid_no_partial", out_valid, 0);
        run_stream(8, 100, -1, 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
